// File: rtl/alu_share_arbiter.sv
// Round-robin front end that shares one ALU between two requesters.
// Ports: req_* (valid/ready + op/A/B), rsp_* (valid/ready + result/zero), busy, alu_* (to/from ALU).
module alu_share_arbiter #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_op0,
  input  logic [1:0]           req_op1,
  input  logic [WORD_SIZE-1:0] req_a0,
  input  logic [WORD_SIZE-1:0] req_a1,
  input  logic [WORD_SIZE-1:0] req_b0,
  input  logic [WORD_SIZE-1:0] req_b1,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_result,
  output logic                 rsp_zero,
  output logic                 busy,
  output logic [1:0]           alu_operation,
  output logic [WORD_SIZE-1:0] alu_operand_a,
  output logic [WORD_SIZE-1:0] alu_operand_b,
  input  logic [WORD_SIZE-1:0] alu_result,
  input  logic                 alu_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_last;
  logic                 r_id;
  logic [1:0]           r_op;
  logic [WORD_SIZE-1:0] r_a;
  logic [WORD_SIZE-1:0] r_b;
  logic [WORD_SIZE-1:0] r_result;
  logic                 r_zero;
  logic                 w_gnt;
  logic                 w_accept;

  // Tie goes to whoever did not win last; otherwise the lone requester.
  always_comb begin
    w_gnt = req_valid[1];
    if (&req_valid)
      w_gnt = ~r_last;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    req_ready = 2'b00;
    unique case (r_state)
      S_IDLE: begin
        // Gate on rst_n so no grant is advertised while held in reset.
        if ((|req_valid) && rst_n) begin
          w_accept  = 1'b1;
          req_ready = w_gnt ? 2'b10 : 2'b01;
          w_next    = S_EXEC;
        end
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        if (rsp_ready[r_id])
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_id   <= w_gnt;
        r_last <= w_gnt;
        r_op   <= w_gnt ? req_op1 : req_op0;
        r_a    <= w_gnt ? req_a1  : req_a0;
        r_b    <= w_gnt ? req_b1  : req_b0;
      end
      if (r_state == S_EXEC) begin
        r_result <= alu_result;
        r_zero   <= alu_zero;
      end
    end
  end

  assign rsp_valid     = (r_state == S_RESP) ?
                         (r_id ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result    = r_result;
  assign rsp_zero      = r_zero;
  assign busy          = (r_state != S_IDLE);
  assign alu_operation = r_op;
  assign alu_operand_a = r_a;
  assign alu_operand_b = r_b;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter.
// A behavioural ALU closes the loop on the alu_* ports.
module tb_alu_share_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_op0, req_op1;
  logic [W-1:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic         busy;
  logic [1:0]   alu_operation;
  logic [W-1:0] alu_operand_a, alu_operand_b;
  logic [W-1:0] alu_result;
  logic         alu_zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_operation)
      2'b00: alu_result = alu_operand_a + alu_operand_b;
      2'b01: alu_result = alu_operand_a - alu_operand_b;
      2'b10: alu_result = alu_operand_a & alu_operand_b;
      default: alu_result = alu_operand_a | alu_operand_b;
    endcase
    alu_zero = (alu_result == '0);
  end

  alu_share_arbiter #(.WORD_SIZE(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .busy(busy),
    .alu_operation(alu_operation),
    .alu_operand_a(alu_operand_a),
    .alu_operand_b(alu_operand_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from a single requester with hand-computed result.
  task automatic one_op(input int id, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ez,
                        input string tag);
    logic [1:0] oh;
    oh = (id == 1) ? 2'b10 : 2'b01;
    if (id == 1) begin
      req_op1 = op; req_a1 = a; req_b1 = b;
    end else begin
      req_op0 = op; req_a0 = a; req_b0 = b;
    end
    req_valid = oh;
    rsp_ready = 2'b00;
    #1;
    chk({tag, "_ready"}, {30'd0, req_ready}, {30'd0, oh});
    tick();
    req_valid = 2'b00;
    chk({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_exec_rv"}, {30'd0, rsp_valid}, 32'd0);
    tick();
    chk({tag, "_rv"}, {30'd0, rsp_valid}, {30'd0, oh});
    chk({tag, "_res"}, {16'd0, rsp_result}, {16'd0, er});
    chk({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, ez});
    rsp_ready = oh;
    tick();
    rsp_ready = 2'b00;
    chk({tag, "_done_rv"}, {30'd0, rsp_valid}, 32'd0);
    chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_op0 = 2'b00; req_op1 = 2'b00;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    repeat (2) tick();
    chk("rst_rv", {30'd0, rsp_valid}, 32'd0);
    chk("rst_res", {16'd0, rsp_result}, 32'd0);
    chk("rst_zero", {31'd0, rsp_zero}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu_a", {16'd0, alu_operand_a}, 32'd0);
    req_valid = 2'b11;
    #1;
    chk("rst_noready", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();

    // Basic ops, including wrap-around to zero.
    one_op(0, 2'b00, 16'h0005, 16'h0003, 16'h0008, 1'b0, "t1_add");
    chk("t1_alu_hold", {16'd0, alu_operand_a}, 32'h0005);
    one_op(1, 2'b01, 16'h0007, 16'h0007, 16'h0000, 1'b1, "t2_sub");
    one_op(1, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, "t2_wrap");

    // Both requesters valid from reset release: strict alternation 0,1,0,1.
    rst_n = 1'b0;
    #2;
    req_op0 = 2'b10; req_a0 = 16'hF0F0; req_b0 = 16'h0FF0;
    req_op1 = 2'b11; req_a1 = 16'hF000; req_b1 = 16'h000F;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t3_gnt%0d", k), {30'd0, req_ready},
          (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      tick();
      chk($sformatf("t3_rv%0d", k), {30'd0, rsp_valid},
          (k % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("t3_res%0d", k), {16'd0, rsp_result},
          (k % 2 == 0) ? 32'h00F0 : 32'hF00F);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();

    // Response stall: owner holds off, other requester valid and ready.
    req_op0 = 2'b00; req_a0 = 16'h1234; req_b0 = 16'h1111;
    req_valid = 2'b01;
    #1;
    chk("t4_gnt", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b10;
    tick();
    rsp_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t4_rv%0d", k), {30'd0, rsp_valid}, 32'd1);
      chk($sformatf("t4_res%0d", k), {16'd0, rsp_result}, 32'h2345);
      chk($sformatf("t4_busy%0d", k), {31'd0, busy}, 32'd1);
      chk($sformatf("t4_rdy%0d", k), {30'd0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    chk("t4_rel_rv", {30'd0, rsp_valid}, 32'd0);
    chk("t4_next_gnt", {30'd0, req_ready}, 32'd2);
    req_valid = 2'b00;
    tick();
    tick();
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;

    // Reset during EXEC: state clears at once, requester 0 wins the tie.
    req_op0 = 2'b00; req_a0 = 16'h0001; req_b0 = 16'h0001;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b11;
    chk("t5_exec_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5e_busy", {31'd0, busy}, 32'd0);
    chk("t5e_rv", {30'd0, rsp_valid}, 32'd0);
    chk("t5e_rdy", {30'd0, req_ready}, 32'd0);
    chk("t5e_alu_a", {16'd0, alu_operand_a}, 32'd0);
    #3;
    rst_n = 1'b1;
    #1;
    chk("t5e_first", {30'd0, req_ready}, 32'd1);

    // Reset during RESP.
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    chk("t5r_rv_pre", {30'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5r_rv", {30'd0, rsp_valid}, 32'd0);
    chk("t5r_busy", {31'd0, busy}, 32'd0);
    chk("t5r_res", {16'd0, rsp_result}, 32'd0);
    #3;
    req_valid = 2'b11;
    rst_n = 1'b1;
    #1;
    chk("t5r_first", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    tick();

    // Withdrawn request while the ALU is busy must not be granted later.
    req_op1 = 2'b11; req_a1 = 16'h00A0; req_b1 = 16'h000B;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("t6_res", {16'd0, rsp_result}, 32'h00AB);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    chk("t6_idle_rdy", {30'd0, req_ready}, 32'd0);
    tick();
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    chk("t6_idle_rv", {30'd0, rsp_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
